// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan path.
// Segment codes are active-low: bit 0 = a ... bit 6 = g, bit 7 = dp.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Hex glyphs with the decimal point off.
  localparam logic [7:0] HEX_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low segment pattern with decimal point merge; purely combinational.
// seg_off darkens a..g only, so a lit decimal point survives leading-zero suppression.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp_on,
  input  logic       seg_off,
  output logic [7:0] seg
);

  always_comb begin
    seg = HEX_LUT[hex];
    if (seg_off) begin
      seg[6:0] = 7'h7F;
    end
    seg[7] = ~dp_on;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner with double-buffered digit load, ghost gap and blank/blink/dp masks.
// Latency: outputs are registered one cycle behind the slot state; loads show from the next frame.
// Backpressure: none; load is a fire-and-forget pulse. SEG_LZ_SUPPRESS_EN enables leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int GAP_CYC      = 500,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   chs,
  output logic [7:0]            oout,
  output logic                  frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_START = CW'(SCAN_DIV - GAP_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  logic [4*N_DIGITS-1:0] stg_dig, sh_dig;
  logic [N_DIGITS-1:0]   stg_blank, stg_blink, stg_dp;
  logic [N_DIGITS-1:0]   sh_blank, sh_blink, sh_dp;
  logic                  pending;
  logic                  sh_vld;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx;
  logic [FW-1:0] frm_cnt;
  logic          blink_phase;
  logic          wrap_q;
  logic          slot_end, wrap;

  scan_state_e   state, state_nxt;
  logic [N_DIGITS-1:0] chs_nxt;
  logic [7:0]    oout_nxt;
  logic [3:0]    cur_dig;
  logic [7:0]    seg_dec;
  logic          dark, suppress;

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  assign cnt_nxt  = slot_end ? '0 : cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      wrap_q <= wrap;
      cnt    <= cnt_nxt;
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      if (wrap) begin
        if (frm_cnt == FRM_LAST) begin
          frm_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frm_cnt <= frm_cnt + FW'(1);
        end
      end
    end
  end

  // Staging absorbs loads at any time; shadow only changes at the frame boundary,
  // so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_dig   <= '0;
      stg_blank <= '1;
      stg_blink <= '0;
      stg_dp    <= '0;
      sh_dig    <= '0;
      sh_blank  <= '1;
      sh_blink  <= '0;
      sh_dp     <= '0;
      pending   <= 1'b0;
      sh_vld    <= 1'b0;
    end else begin
      if (load) begin
        stg_dig   <= digits;
        stg_blank <= blank_mask;
        stg_blink <= blink_mask;
        stg_dp    <= dp_mask;
      end
      if (wrap && pending) begin
        sh_dig   <= stg_dig;
        sh_blank <= stg_blank;
        sh_blink <= stg_blink;
        sh_dp    <= stg_dp;
        sh_vld   <= 1'b1;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  assign cur_dig = sh_dig[{idx, 2'b00} +: 4];
  assign dark    = sh_blank[idx] | (sh_blink[idx] & blink_phase);

`ifdef SEG_LZ_SUPPRESS_EN
  logic [N_DIGITS-1:0] lz;
  logic                zero_above;

  // A blanked digit counts as zero when deciding whether lower zeros are leading.
  always_comb begin
    lz         = '0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      lz[i]      = zero_above && (sh_dig[4*i +: 4] == 4'h0);
      zero_above = zero_above && (sh_blank[i] || (sh_dig[4*i +: 4] == 4'h0));
    end
  end

  assign suppress = lz[idx];
`else
  assign suppress = 1'b0;
`endif

  hex_to_seg u_dec (
    .hex     (cur_dig),
    .dp_on   (sh_dp[idx]),
    .seg_off (suppress),
    .seg     (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SHOW;
    end else begin
      state <= state_nxt;
    end
  end

  // Selects stay released until the first frame of loaded data reaches the shadow.
  always_comb begin
    state_nxt = state;
    chs_nxt   = '1;
    oout_nxt  = SEG_OFF;
    case (state)
      SHOW:    if ((GAP_CYC != 0) && (cnt_nxt == GAP_START)) state_nxt = GAP;
      GAP:     if (slot_end) state_nxt = SHOW;
      default: state_nxt = SHOW;
    endcase
    if ((state == SHOW) && sh_vld) begin
      chs_nxt[idx] = 1'b0;
      if (!dark) begin
        oout_nxt = seg_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chs         <= '1;
      oout        <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      chs         <= chs_nxt;
      oout        <= oout_nxt;
      frame_start <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: slot/frame arithmetic model checked every cycle, plus pinned literal points.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int GAP   = 2;
  localparam int BF    = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  dp_mask = '0;
  logic        load = 1'b0;
  logic [3:0]  chs;
  logic [7:0]  oout;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .N_DIGITS     (N),
    .SCAN_DIV     (DIV),
    .GAP_CYC      (GAP),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits      (digits),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .dp_mask     (dp_mask),
    .load        (load),
    .chs         (chs),
    .oout        (oout),
    .frame_start (frame_start)
  );

  int checks = 0;
  int failures = 0;
  int cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Record of every load: the cycle position it was sampled at and its data.
  int          n_ld = 0;
  int          ld_pos   [16];
  logic [15:0] ld_dig   [16];
  logic [3:0]  ld_blank [16];
  logic [3:0]  ld_blink [16];
  logic [3:0]  ld_dp    [16];

  localparam int N_LIT = 16;
  localparam int         LIT_P   [N_LIT] = '{0, 32, 64, 70, 72, 96, 104, 128, 192, 200, 256, 288, 304, 312, 336, 344};
  localparam logic [3:0] LIT_CHS [N_LIT] = '{4'hF, 4'hF, 4'hE, 4'hF, 4'hD, 4'hE, 4'hD, 4'hE,
                                             4'hE, 4'hD, 4'hE, 4'hE, 4'hB, 4'h7, 4'hB, 4'h7};
`ifdef SEG_LZ_SUPPRESS_EN
  localparam logic [7:0] LIT_OUT [N_LIT] = '{8'hFF, 8'hFF, 8'h99, 8'hFF, 8'hB0, 8'h80, 8'hF8, 8'h99,
                                             8'hFF, 8'hB0, 8'h99, 8'hC0, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
`else
  localparam logic [7:0] LIT_OUT [N_LIT] = '{8'hFF, 8'hFF, 8'h99, 8'hFF, 8'hB0, 8'h80, 8'hF8, 8'h99,
                                             8'hFF, 8'hB0, 8'h99, 8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hFF};
`endif

  function automatic logic [7:0] lut(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // p = cycles since reset release whose state the outputs reflect.
  task automatic model(input int p, output logic [3:0] e_chs, output logic [7:0] e_oout, output logic e_fs);
    int f, di, cn, sel;
    logic [3:0] d;
    logic phase;
`ifdef SEG_LZ_SUPPRESS_EN
    logic zero_above;
`endif
    f  = p / FRAME;
    di = (p / DIV) % N;
    cn = p % DIV;
    e_fs   = (p % FRAME == 0) && (p > 0);
    e_chs  = 4'hF;
    e_oout = 8'hFF;
    sel = -1;
    for (int k = 0; k < n_ld; k++) if (ld_pos[k] < f * FRAME - 1) sel = k;
    if (cn < DIV - GAP && sel >= 0) begin
      e_chs[di] = 1'b0;
      d = ld_dig[sel][4*di +: 4];
      phase = ((f / BF) % 2) == 1;
      if (!(ld_blank[sel][di] || (ld_blink[sel][di] && phase))) begin
        e_oout = lut(d);
`ifdef SEG_LZ_SUPPRESS_EN
        zero_above = 1'b1;
        for (int j = di + 1; j < N; j++)
          if (!(ld_blank[sel][j] || ld_dig[sel][4*j +: 4] == 4'h0)) zero_above = 1'b0;
        if (di > 0 && d == 4'h0 && zero_above) e_oout[6:0] = 7'h7F;
`endif
        e_oout[7] = ~ld_dp[sel][di];
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  logic [3:0] e_chs;
  logic [7:0] e_oout;
  logic       e_fs;

  always @(negedge clk) begin
    if (rst_n && cyc >= 1) begin
      model(cyc - 1, e_chs, e_oout, e_fs);
      chk("scan", {19'd0, chs, oout, frame_start}, {19'd0, e_chs, e_oout, e_fs});
      for (int i = 0; i < N_LIT; i++) begin
        if (LIT_P[i] == cyc - 1) begin
          chk("lit_dut", {20'd0, chs, oout}, {20'd0, LIT_CHS[i], LIT_OUT[i]});
          chk("lit_model", {20'd0, e_chs, e_oout}, {20'd0, LIT_CHS[i], LIT_OUT[i]});
        end
      end
    end
  end

  task automatic do_load(input int c, input logic [15:0] dg, input logic [3:0] bl,
                         input logic [3:0] bk, input logic [3:0] dp);
    while (cyc < c) @(negedge clk);
    ld_pos[n_ld]   = cyc;
    ld_dig[n_ld]   = dg;
    ld_blank[n_ld] = bl;
    ld_blink[n_ld] = bk;
    ld_dp[n_ld]    = dp;
    n_ld++;
    digits = dg; blank_mask = bl; blink_mask = bk; dp_mask = dp;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("reset_chs", {28'd0, chs}, 32'hF);
      chk("reset_oout", {24'd0, oout}, 32'hFF);
      chk("reset_fs", {31'd0, frame_start}, 32'd0);
    end
    rst_n = 1'b1;

    do_load(40,  16'h1234, 4'b0000, 4'b0000, 4'b0000);
    do_load(70,  16'h1234, 4'b0000, 4'b0000, 4'b0000);
    do_load(72,  16'h5678, 4'b0000, 4'b0000, 4'b0000);
    do_load(100, 16'h1234, 4'b0000, 4'b0001, 4'b0000);
    do_load(255, 16'h0000, 4'b0000, 4'b0000, 4'b0100);
    do_load(300, 16'h50A0, 4'b1000, 4'b0000, 4'b0000);

    while (cyc < 354) @(negedge clk);
    #2;
    chk("pre_arst_chs", {28'd0, chs}, 32'hE);
    rst_n = 1'b0;
    #1;
    chk("arst_chs", {28'd0, chs}, 32'hF);
    chk("arst_oout", {24'd0, oout}, 32'hFF);
    chk("arst_fs", {31'd0, frame_start}, 32'd0);
    n_ld = 0;
    repeat (2) begin
      @(negedge clk);
      chk("arst_hold_chs", {28'd0, chs}, 32'hF);
      chk("arst_hold_oout", {24'd0, oout}, 32'hFF);
    end
    rst_n = 1'b1;
    while (cyc < 40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
